// File: rtl/sigmoid_arbiter.sv
// ---------------------------------------------------------------------------
// sigmoid_arbiter
//   Round-robin sharing of one combinational sigmoid look-up ROM among
//   NUM_REQ activation requesters. A granted signed Q8.8 value is clamped to
//   +/-6.0 and mapped to ROM index k (x = -6.0 + 0.1*k, k = 0..120). The ROM
//   word (sigmoid * 256) is returned with the requester ID over a valid/ready
//   response port. One request is in flight at a time.
//
// Ports
//   clk        : clock, rising edge
//   rst        : asynchronous active-high reset
//   req_valid  : [NUM_REQ]     per-requester request valid
//   req_data   : [NUM_REQ*16]  per-requester Q8.8 value, requester i at [16i+15:16i]
//   req_ready  : [NUM_REQ]     one-hot grant (combinational, IDLE only)
//   rom_addr   : [7]           registered ROM index, 0..120
//   rom_data   : [16]          ROM word, combinational from rom_addr
//   rsp_valid  : response valid
//   rsp_ready  : response consumer ready
//   rsp_data   : [16]          sigmoid * 256
//   rsp_id     : [ID_W]        served requester
//
// Build option
//   SIGMOID_SAT_BYPASS_EN : values beyond +/-6.0 answer 0x0000 / 0x0100
//                           directly from ADDR, skipping the ROM read.
// ---------------------------------------------------------------------------
module sigmoid_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*16-1:0] req_data,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [6:0]            rom_addr,
  input  logic [15:0]           rom_data,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [15:0]           rsp_data,
  output logic [ID_W-1:0]       rsp_id
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned U_W    = 12;
  localparam int unsigned PROD_W = 15;

  // +/-6.0 in Q8.8
  localparam logic signed [DATA_W-1:0] X_MIN = -16'sd1536;
  localparam logic signed [DATA_W-1:0] X_MAX = 16'sd1536;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_READ,
    S_RESP
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;

  logic [ID_W-1:0]           r_rr_ptr;
  logic [ID_W-1:0]           r_id;
  logic signed [DATA_W-1:0]  r_x;
  logic [ADDR_W-1:0]         r_rom_addr;
  logic                      r_rsp_valid;
  logic [DATA_W-1:0]         r_rsp_data;
  logic [ID_W-1:0]           r_rsp_id;

  logic                      w_grant_vld;
  logic [ID_W-1:0]           w_grant_id;
  logic [ID_W-1:0]           w_ptr_nxt;
  logic signed [DATA_W-1:0]  w_x_sel;
  logic signed [DATA_W-1:0]  w_x_clamp;
  logic [U_W-1:0]            w_u;
  logic [PROD_W-1:0]         w_prod;
  logic [ADDR_W-1:0]         w_k;

`ifdef SIGMOID_SAT_BYPASS_EN
  logic                      w_sat_lo;
  logic                      w_sat_hi;
`endif

  // First valid requester at or above rr_ptr, wrapping modulo NUM_REQ
  always_comb begin : rr_search
    logic [ID_W:0] v_sum;
    v_sum       = '0;
    w_grant_vld = 1'b0;
    w_grant_id  = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      v_sum = {1'b0, r_rr_ptr} + (ID_W+1)'(off);
      if (v_sum >= (ID_W+1)'(NUM_REQ)) begin
        v_sum = v_sum - (ID_W+1)'(NUM_REQ);
      end
      if (!w_grant_vld && req_valid[ID_W'(v_sum)]) begin
        w_grant_vld = 1'b1;
        w_grant_id  = ID_W'(v_sum);
      end
    end
  end

  // Pointer advances past the winner
  assign w_ptr_nxt = (w_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_id + ID_W'(1);

  // Data of the winning requester
  always_comb begin
    w_x_sel = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_grant_id == ID_W'(i)) begin
        w_x_sel = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Grant only in IDLE and never while reset is asserted
  always_comb begin
    req_ready = '0;
    if (!rst && (r_state == S_IDLE) && w_grant_vld) begin
      req_ready[w_grant_id] = 1'b1;
    end
  end

  // Clamp to +/-6.0
  always_comb begin
    w_x_clamp = r_x;
    if (r_x < X_MIN) begin
      w_x_clamp = X_MIN;
    end else if (r_x > X_MAX) begin
      w_x_clamp = X_MAX;
    end
  end

  // k = round(u * 10 / 256), u = x + 6.0 in Q8.8; u <= 3072 so k <= 120
  assign w_u    = U_W'(w_x_clamp + X_MAX);
  assign w_prod = PROD_W'(w_u) * PROD_W'(10) + PROD_W'(128);
  assign w_k    = ADDR_W'(w_prod >> 8);

`ifdef SIGMOID_SAT_BYPASS_EN
  assign w_sat_lo = (r_x < X_MIN);
  assign w_sat_hi = (r_x > X_MAX);
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_grant_vld) begin
          w_state_nxt = S_ADDR;
        end
      end
      S_ADDR: begin
`ifdef SIGMOID_SAT_BYPASS_EN
        w_state_nxt = (w_sat_lo || w_sat_hi) ? S_RESP : S_READ;
`else
        w_state_nxt = S_READ;
`endif
      end
      S_READ: begin
        w_state_nxt = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath registers; everything holds unless its state loads it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_x         <= '0;
      r_rom_addr  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_id    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_vld) begin
            r_x      <= w_x_sel;
            r_id     <= w_grant_id;
            r_rr_ptr <= w_ptr_nxt;
          end
        end
        S_ADDR: begin
`ifdef SIGMOID_SAT_BYPASS_EN
          // Saturated inputs answer directly; rom_addr keeps its old value
          if (w_sat_lo || w_sat_hi) begin
            r_rsp_data  <= w_sat_hi ? 16'h0100 : 16'h0000;
            r_rsp_id    <= r_id;
            r_rsp_valid <= 1'b1;
          end else begin
            r_rom_addr <= w_k;
          end
`else
          r_rom_addr <= w_k;
`endif
        end
        S_READ: begin
          r_rsp_data  <= rom_data;
          r_rsp_id    <= r_id;
          r_rsp_valid <= 1'b1;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign rom_addr  = r_rom_addr;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_id    = r_rsp_id;

endmodule

// File: tb/tb_sigmoid_arbiter.sv
// ---------------------------------------------------------------------------
// tb_sigmoid_arbiter
//   Directed bench for sigmoid_arbiter. A behavioural sigmoid ROM drives
//   rom_data. Each observed grant pushes the expected response onto a
//   scoreboard queue; each response handshake pops and compares it.
//   Honours SIGMOID_SAT_BYPASS_EN in its expectations.
// ---------------------------------------------------------------------------
module tb_sigmoid_arbiter;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;

  logic                  clk;
  logic                  rst;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ*16-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic [6:0]            rom_addr;
  logic [15:0]           rom_data;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [15:0]           rsp_data;
  logic [ID_W-1:0]       rsp_id;

  sigmoid_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sigmoid ROM: entry k holds round(256 * sigmoid(-6 + 0.1k))
  function automatic logic [15:0] rom_val(input logic [6:0] k);
    real xr;
    real s;
    xr = -6.0 + 0.1 * real'(k);
    s  = 256.0 / (1.0 + $exp(-xr));
    return 16'($rtoi(s + 0.5));
  endfunction

  assign rom_data = rom_val(rom_addr);

  typedef struct {
    logic [ID_W-1:0] id;
    logic [15:0]     data;
    logic [6:0]      addr;
    logic            chk_addr;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   grant_cyc_log[$];

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   grant_cyc;
  int   rise_cyc;
  int   rsp_cnt  = 0;
  logic prev_valid = 1'b0;
  logic hold_all   = 1'b0;
  logic [15:0]     last_data;
  logic [ID_W-1:0] last_id;
  logic [6:0]      last_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: real-valued clamp and nearest grid point
  function automatic exp_t model(input int id, input logic [15:0] x);
    exp_t e;
    real  xr;
    int   k;
    e.id       = ID_W'(id);
    e.chk_addr = 1'b1;
    e.addr     = '0;
    e.data     = '0;
    xr = real'($signed(x)) / 256.0;
`ifdef SIGMOID_SAT_BYPASS_EN
    if (xr < -6.0) begin
      e.data = 16'h0000; e.chk_addr = 1'b0; return e;
    end
    if (xr > 6.0) begin
      e.data = 16'h0100; e.chk_addr = 1'b0; return e;
    end
`endif
    if (xr < -6.0) xr = -6.0;
    if (xr > 6.0)  xr = 6.0;
    k = $rtoi($floor((xr + 6.0) * 10.0 + 0.5));
    e.addr = 7'(k);
    e.data = rom_val(7'(k));
    return e;
  endfunction

  // One clock: monitor at negedge, then advance past the rising edge
  task automatic tick();
    logic [NUM_REQ-1:0] granted;
    exp_t e;
    granted = '0;
    @(negedge clk);
    check("grant_onehot", 32'($countones(req_ready) <= 1), 32'd1);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i] && req_valid[i]) begin
        granted[i] = 1'b1;
        sb.push_back(model(i, req_data[16*i +: 16]));
        grant_log.push_back(i);
        grant_cyc_log.push_back(cyc);
        grant_cyc = cyc;
      end
    end
    if (rsp_valid && !prev_valid) rise_cyc = cyc;
    prev_valid = rsp_valid;
    if (rsp_valid && rsp_ready) begin
      rsp_cnt++;
      if (sb.size() == 0) begin
        check("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        check("sb_data", 32'(rsp_data), 32'(e.data));
        check("sb_id",   32'(rsp_id),   32'(e.id));
        if (e.chk_addr) check("sb_addr", 32'(rom_addr), 32'(e.addr));
        last_data = rsp_data;
        last_id   = rsp_id;
        last_addr = rom_addr;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!hold_all) req_valid = req_valid & ~granted;
  endtask

  task automatic send(input int i, input logic [15:0] x);
    req_data[16*i +: 16] = x;
    req_valid[i]         = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while ((sb.size() != 0 || req_valid != '0 || rsp_valid) && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, 32'(n < 200), 32'd1);
  endtask

  initial begin
    int n;
    logic [15:0]     d0;
    logic [ID_W-1:0] id0;
    int exp_order[5];

    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b1;

    // Reset values; grants suppressed while rst is high
    tick();
    req_valid[0] = 1'b1;
    tick();
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_rom_addr",  32'(rom_addr),  32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data",  32'(rsp_data),  32'd0);
    check("rst_rsp_id",    32'(rsp_id),    32'd0);
    req_valid = '0;
    rst = 1'b0;

    // x = 0.0 from requester 0
    send(0, 16'h0000);
    wait_idle("A");
    check("A_addr", 32'(last_addr), 32'd60);
    check("A_data", 32'(last_data), 32'h0080);
    check("A_id",   32'(last_id),   32'd0);
    check("A_lat",  32'(rise_cyc - grant_cyc), 32'd3);

    // x = 1.0 from requester 2
    send(2, 16'h0100);
    wait_idle("B");
    check("B_addr", 32'(last_addr), 32'd70);
    check("B_data", 32'(last_data), 32'h00BB);
    check("B_id",   32'(last_id),   32'd2);

    // Most negative input from requester 1
    send(1, 16'h8000);
    wait_idle("C");
    check("C_id", 32'(last_id), 32'd1);
`ifdef SIGMOID_SAT_BYPASS_EN
    check("C_data", 32'(last_data), 32'h0000);
    check("C_addr", 32'(last_addr), 32'd70);
    check("C_lat",  32'(rise_cyc - grant_cyc), 32'd2);
`else
    check("C_data", 32'(last_data), 32'h0001);
    check("C_addr", 32'(last_addr), 32'd0);
    check("C_lat",  32'(rise_cyc - grant_cyc), 32'd3);
`endif

    // Most positive input, then the exact clamp limits
    send(3, 16'h7FFF);
    wait_idle("D");
`ifdef SIGMOID_SAT_BYPASS_EN
    check("D_data", 32'(last_data), 32'h0100);
`else
    check("D_data", 32'(last_data), 32'h00FF);
    check("D_addr", 32'(last_addr), 32'd120);
`endif
    send(0, 16'h0600);
    wait_idle("E");
    check("E_data", 32'(last_data), 32'h00FF);
    check("E_addr", 32'(last_addr), 32'd120);
    send(1, 16'hFA00);
    wait_idle("F");
    check("F_data", 32'(last_data), 32'h0001);
    check("F_addr", 32'(last_addr), 32'd0);
    send(2, 16'h0080);
    wait_idle("G");
    send(3, 16'hFF00);
    wait_idle("H");

    // All four requesting continuously: pointer is back at 0
    grant_log.delete();
    grant_cyc_log.delete();
    hold_all = 1'b1;
    send(0, 16'h0123);
    send(1, 16'hFE80);
    send(2, 16'h0345);
    send(3, 16'hFC10);
    n = 0;
    while (grant_log.size() < 5 && n < 60) begin
      tick();
      n++;
    end
    hold_all  = 1'b0;
    req_valid = '0;
    check("RR_timeout", 32'(grant_log.size()), 32'd5);
    exp_order = '{0, 1, 2, 3, 0};
    for (int j = 0; j < 5 && j < grant_log.size(); j++) begin
      check("RR_order", 32'(grant_log[j]), 32'(exp_order[j]));
      if (j > 0) check("RR_spacing", 32'(grant_cyc_log[j] - grant_cyc_log[j-1]), 32'd4);
    end
    wait_idle("RR");

    // Backpressure: pointer now at 1
    rsp_ready = 1'b0;
    send(1, 16'hFE00);
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
    end
    check("BP_rsp_rise", 32'(rsp_valid), 32'd1);
    send(3, 16'h0200);
    d0  = rsp_data;
    id0 = rsp_id;
    check("BP_id", 32'(id0), 32'd1);
    for (int j = 0; j < 10; j++) begin
      tick();
      check("BP_valid",     32'(rsp_valid), 32'd1);
      check("BP_data",      32'(rsp_data),  32'(d0));
      check("BP_id_hold",   32'(rsp_id),    32'(id0));
      check("BP_req_ready", 32'(req_ready), 32'd0);
    end
    n = rsp_cnt;
    rsp_ready = 1'b1;
    tick();
    check("BP_handshake", 32'(rsp_cnt - n), 32'd1);
    check("BP_valid_clr", 32'(rsp_valid),   32'd0);
    wait_idle("BP");

    // Reset during READ: pointer at 0, grant goes to requester 2
    send(2, 16'h0040);
    tick();
    tick();
    check("R_addr_pre", 32'(rom_addr), 32'd63);
    send(0, 16'h0200);
    send(3, 16'hFF80);
    rst = 1'b1;
    #1;
    check("R_req_ready", 32'(req_ready), 32'd0);
    check("R_rom_addr",  32'(rom_addr),  32'd0);
    check("R_rsp_valid", 32'(rsp_valid), 32'd0);
    check("R_rsp_data",  32'(rsp_data),  32'd0);
    check("R_rsp_id",    32'(rsp_id),    32'd0);
    sb.delete();
    grant_log.delete();
    tick();
    check("R_req_ready_hold", 32'(req_ready), 32'd0);
    rst = 1'b0;
    wait_idle("R");
    check("R_grant_cnt", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() >= 2) begin
      check("R_first_grant",  32'(grant_log[0]), 32'd0);
      check("R_second_grant", 32'(grant_log[1]), 32'd3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
